mmio_client_mux: RTL and testbench
==================================

// Module: mmio_client_mux
// PURPOSE
// Multi-client, multi-outstanding successor to the single-outstanding MMIO front end of the ethernet wrapper.
// Sits between an AXI-lite client adaptor request/response stream and num_clients_p sync-read MMIO cores.
// - Decodes each address to one client region and allows up to outstanding_p in-order requests.
// - Packs read data by size and byte offset; flags misaligned, oversize and unmapped accesses.
// - Aggregates client interrupts into one registered irq.
// PARAMETERS
// data_width_p        32  request/response data width (bits, multiple of 8)
// addr_width_p        32  request address width
// num_clients_p       2   number of client regions/cores
// client_addr_width_p 16  log2 bytes per client region
// base_addr_p         0   address of client 0 region
// outstanding_p       4   max requests in flight (stage-1 reg + resp fifo); >=2
// PORTS
// clk_i            in   1                          clock
// reset_n_i        in   1                          async active-low reset
// v_i              in   1                          request valid
// ready_and_o      out  1                          request ready (valid-and-ready handshake)
// addr_i           in   addr_width_p               request byte address
// wr_en_i          in   1                          1=write, 0=read
// size_i           in   2                          log2 bytes (0=1B..3=8B)
// wdata_i          in   data_width_p               write data
// v_o              out  1                          response valid
// ready_and_i      in   1                          response consumer ready
// rdata_o          out  data_width_p               read data, zero-extended; 0 for writes/errors
// err_o            out  1                          response error flag
// client_addr_o    out  client_addr_width_p        offset within region, broadcast
// client_size_o    out  2                          size, broadcast
// client_wdata_o   out  data_width_p               write data, broadcast
// client_w_v_o     out  num_clients_p              one-hot write strobe
// client_r_v_o     out  num_clients_p              one-hot read strobe
// client_rdata_i   in   num_clients_p*data_width_p  client read data, 1 cycle after client_r_v_o
// client_rdata_v_i in   num_clients_p              client read data valid
// irq_i            in   num_clients_p              level interrupts from clients
// irq_o            out  1                          registered OR of irq_i
// BEHAVIOUR
// - Reset (reset_n_i=0, async): credits=0; stage-1 and fifo cleared; in-flight requests dropped, no responses.
//   - All outputs low during and after reset: ready_and_o, v_o, err_o, rdata_o, client_*_v_o, irq_o.
//   - ready_and_o rises the first cycle after deassert.
// - Accept: v_i & ready_and_o; ready_and_o = (credits < outstanding_p).
// - credits: +1 on accept, -1 on v_o & ready_and_i; both same cycle -> unchanged.
// - Decode:
//   - off = addr_i - base_addr_p; idx = off >> client_addr_width_p.
//   - Unmapped if addr_i < base_addr_p or idx >= num_clients_p.
//   - Misaligned if addr_i mod 2^size_i != 0.
//   - Oversize if 2^size_i > data_width_p/8.
//   - Any error: no client strobe; response err_o=1, rdata_o=0.
// - Issue (accept cycle t, no error): client_w_v_o[idx] or client_r_v_o[idx] combinationally in cycle t.
//   - client_addr_o = off[client_addr_width_p-1:0].
// - Stage 1 register (cycle t+1) holds {is_read, idx, size, byte sel=addr_i low bits, err}. Every accepted request pushes exactly one fifo entry at t+1 -> in order, never more than one push per cycle.
// - Read in stage 1:
//   - client_rdata_v_i[idx]=1: data = client_rdata_i[idx] >> (8*sel), masked to 2^size bytes, err=0.
//   - Otherwise: timeout, err=1, rdata=0.
// - Write in stage 1: pushes err=0, rdata=0.
// - Resp fifo: depth outstanding_p, registered output; first response v_o at t+2 minimum.
//   - Never overflows (credits bound it); push while full is an assertion failure.
// - Back-to-back: one request per cycle sustained while credits allow and ready_and_i=1.
// - irq_o = |irq_i, registered 1 cycle.
// TESTING
// - Reset mid-flight: 3 reads outstanding, pulse reset_n_i low -> v_o=0, no stale responses after; ready_and_o=1 next cycle after release.
// - Write then read (32-bit, client 1):
//   - Write 0x0001_0004 wdata 0xA5A5_1234 -> client_w_v_o=2'b10, client_addr_o=0x0004, response err=0 at t+2.
//   - Read returning 0xCAFE_F00D -> rdata_o=0xCAFE_F00D.
// - Byte read at addr 0x0000_0002, client returns 0x1122_3344 -> rdata_o=0x0000_0022, err_o=0.
// - Errors -> no client strobe, err_o=1, rdata_o=0:
//   - addr 0x0002_0000 (unmapped).
//   - Halfword read at 0x0000_0001 (misaligned).
//   - size_i=3 on 32-bit bus (oversize).
// - Credit limit: ready_and_i=0, 5 requests offered -> 4 accepted, ready_and_o=0. Drain -> 4 in-order responses, then 5th accepted.
// - Timeout, irq: client 0 withholds client_rdata_v_i -> err_o=1. irq_i=2'b01 -> irq_o=1 one cycle later.

Source files
------------

// File: rtl/mmio_client_mux_if.sv
// Request/response stream between the AXI-lite client adaptor and mmio_client_mux.
// Signal names keep the mux's point of view (_i into the mux, _o out of it).
interface mmio_client_mux_if #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32
);
  logic                    v_i;
  logic                    ready_and_o;
  logic [addr_width_p-1:0] addr_i;
  logic                    wr_en_i;
  logic [1:0]              size_i;
  logic [data_width_p-1:0] wdata_i;
  logic                    v_o;
  logic                    ready_and_i;
  logic [data_width_p-1:0] rdata_o;
  logic                    err_o;

  modport slave (
    input  v_i, addr_i, wr_en_i, size_i, wdata_i, ready_and_i,
    output ready_and_o, v_o, rdata_o, err_o
  );

  modport master (
    output v_i, addr_i, wr_en_i, size_i, wdata_i, ready_and_i,
    input  ready_and_o, v_o, rdata_o, err_o
  );
endinterface

// File: rtl/mmio_client_mux.sv
// Multi-client, multi-outstanding MMIO front end: decodes requests to sync-read client
// cores, keeps responses in order through a credit-bounded fifo, and registers the irq OR.
module mmio_client_mux #(
  parameter int                      data_width_p        = 32,
  parameter int                      addr_width_p        = 32,
  parameter int                      num_clients_p       = 2,
  parameter int                      client_addr_width_p = 16,
  parameter logic [addr_width_p-1:0] base_addr_p         = '0,
  parameter int                      outstanding_p       = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  mmio_client_mux_if.slave                      bus,
  output logic [client_addr_width_p-1:0]        client_addr_o,
  output logic [1:0]                            client_size_o,
  output logic [data_width_p-1:0]               client_wdata_o,
  output logic [num_clients_p-1:0]              client_w_v_o,
  output logic [num_clients_p-1:0]              client_r_v_o,
  input  logic [num_clients_p*data_width_p-1:0] client_rdata_i,
  input  logic [num_clients_p-1:0]              client_rdata_v_i,
  input  logic [num_clients_p-1:0]              irq_i,
  output logic                                  irq_o
);
  localparam int bytes_lp     = data_width_p / 8;
  localparam int sel_width_lp = (bytes_lp > 1) ? $clog2(bytes_lp) : 1;
  localparam int idx_width_lp = (num_clients_p > 1) ? $clog2(num_clients_p) : 1;
  localparam int cred_width_lp = $clog2(outstanding_p + 1);
  localparam int ptr_width_lp  = $clog2(outstanding_p);
  localparam logic [2:0] max_size_lp = 3'($clog2(bytes_lp));

  logic [addr_width_p-1:0]  off, idx_full, align_mask;
  logic [idx_width_lp-1:0]  idx;
  logic                     unmapped, misaligned, oversize, req_err;
  logic                     accept, issue, pop, push, ready_en;
  logic [num_clients_p-1:0] idx_onehot;
  logic [cred_width_lp-1:0] credits;

  assign off        = bus.addr_i - base_addr_p;
  assign idx_full   = off >> client_addr_width_p;
  assign idx        = idx_full[idx_width_lp-1:0];
  assign unmapped   = (bus.addr_i < base_addr_p) || (idx_full >= addr_width_p'(num_clients_p));
  assign align_mask = ~({addr_width_p{1'b1}} << bus.size_i);
  assign misaligned = |(bus.addr_i & align_mask);
  assign oversize   = {1'b0, bus.size_i} > max_size_lp;
  assign req_err    = unmapped | misaligned | oversize;

  assign bus.ready_and_o = ready_en & (credits < cred_width_lp'(outstanding_p));
  assign accept     = bus.v_i & bus.ready_and_o;
  assign issue      = accept & ~req_err;
  assign idx_onehot = num_clients_p'(1) << idx;

  assign client_w_v_o   = (issue &  bus.wr_en_i) ? idx_onehot : '0;
  assign client_r_v_o   = (issue & ~bus.wr_en_i) ? idx_onehot : '0;
  assign client_addr_o  = off[client_addr_width_p-1:0];
  assign client_size_o  = bus.size_i;
  assign client_wdata_o = bus.wdata_i;

  // Credits count stage 1 plus fifo occupancy, so they alone bound the fifo.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credits  <= '0;
      ready_en <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      irq_o    <= |irq_i;
      case ({accept, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: ;
      endcase
    end
  end

  logic                    s1_v, s1_read, s1_err;
  logic [idx_width_lp-1:0] s1_idx;
  logic [1:0]              s1_size;
  logic [sel_width_lp-1:0] s1_sel;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_v    <= 1'b0;
      s1_read <= 1'b0;
      s1_err  <= 1'b0;
      s1_idx  <= '0;
      s1_size <= '0;
      s1_sel  <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_read <= ~bus.wr_en_i;
        s1_err  <= req_err;
        s1_idx  <= idx;
        s1_size <= bus.size_i;
        s1_sel  <= (bytes_lp > 1) ? bus.addr_i[sel_width_lp-1:0] : '0;
      end
    end
  end

  logic [data_width_p-1:0] lane, shifted, masked, push_data;
  logic                    lane_v, push_err;

  // Client data arrives while the request sits in stage 1; align and trim it here.
  always_comb begin
    lane   = '0;
    lane_v = 1'b0;
    for (int c = 0; c < num_clients_p; c++) begin
      if (s1_idx == idx_width_lp'(c)) begin
        lane   = client_rdata_i[c*data_width_p +: data_width_p];
        lane_v = client_rdata_v_i[c];
      end
    end
    shifted = lane >> {s1_sel, 3'b000};
    masked  = '0;
    for (int b = 0; b < bytes_lp; b++) begin
      if (b < (1 << s1_size)) masked[8*b +: 8] = shifted[8*b +: 8];
    end
    push_err  = s1_err | (s1_read & ~lane_v);
    push_data = (s1_read & ~push_err) ? masked : '0;
  end

  logic [data_width_p-1:0]  fifo_data [outstanding_p];
  logic                     fifo_err  [outstanding_p];
  logic [ptr_width_lp-1:0]  wr_ptr, rd_ptr;
  logic [cred_width_lp-1:0] count;

  assign push = s1_v;
  assign pop  = bus.v_o & bus.ready_and_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_err[wr_ptr]  <= push_err;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == ptr_width_lp'(outstanding_p - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == ptr_width_lp'(outstanding_p - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.v_o     = (count != '0);
  assign bus.rdata_o = bus.v_o ? fifo_data[rd_ptr] : '0;
  assign bus.err_o   = bus.v_o & fifo_err[rd_ptr];

  push_while_full_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(push && (count == cred_width_lp'(outstanding_p))));
endmodule

// File: tb/tb_mmio_client_mux.sv
// Randomized bench for mmio_client_mux: an in-order expected-response queue and a
// behavioural client model predict every strobe, handshake, response and irq.
module tb_mmio_client_mux;
  localparam int DW = 32, AW = 32, NC = 2, CAW = 16, OUTS = 4;
  localparam logic [31:0] BASE = 32'h0;

  logic              clk_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic [CAW-1:0]    client_addr_o;
  logic [1:0]        client_size_o;
  logic [DW-1:0]     client_wdata_o;
  logic [NC-1:0]     client_w_v_o, client_r_v_o, client_rdata_v_i, irq_i;
  logic [NC*DW-1:0]  client_rdata_i;
  logic              irq_o;

  mmio_client_mux_if #(.data_width_p(DW), .addr_width_p(AW)) bus ();

  mmio_client_mux #(
    .data_width_p(DW), .addr_width_p(AW), .num_clients_p(NC),
    .client_addr_width_p(CAW), .base_addr_p(BASE), .outstanding_p(OUTS)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus),
    .client_addr_o(client_addr_o), .client_size_o(client_size_o),
    .client_wdata_o(client_wdata_o), .client_w_v_o(client_w_v_o),
    .client_r_v_o(client_r_v_o), .client_rdata_i(client_rdata_i),
    .client_rdata_v_i(client_rdata_v_i), .irq_i(irq_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int unsigned cyc; logic err; logic [31:0] data; } resp_t;
  resp_t expQ[$];

  int          testsRun = 0, testsFailed = 0, acceptCount = 0, withholdPct = 12;
  int unsigned cycleNum = 0;
  bit          readyArmed = 0, irqPrev = 0, lastAccepted = 0;
  bit          schedPending = 0, schedValid = 0, forceDataEn = 0, forceWithhold = 0;
  int          schedIdx = 0;
  logic [31:0] schedData, forceData, lastRespData;
  logic        lastRespErr;

  task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycleNum);
    end
  endtask

  function automatic bit reqError(logic [31:0] addr, logic [1:0] size);
    longint unsigned a;
    int unsigned     bytes;
    bit              unmapped, misaligned, oversize;
    a          = addr;
    bytes      = 1 << size;
    unmapped   = (a < BASE) || (((a - BASE) >> CAW) >= NC);
    misaligned = (a % bytes) != 0;
    oversize   = bytes > DW / 8;
    return unmapped || misaligned || oversize;
  endfunction

  function automatic logic [31:0] readValue(logic [31:0] raw, logic [31:0] addr, logic [1:0] size);
    longint unsigned v;
    int unsigned     bytes;
    bytes = 1 << size;
    v = raw;
    v = v >> (8 * (addr % (DW / 8)));
    v = v % (64'd1 << (8 * bytes));
    return v[31:0];
  endfunction

  // One clock: check everything at the negedge, update the model, then drive client lanes.
  task automatic runCycle();
    logic          expReady, accept, err;
    logic [NC-1:0] expW, expR;
    bit            expV;
    int            idx;
    resp_t         r;
    @(negedge clk_i);
    cycleNum++;
    lastAccepted = 0;
    if (!reset_n_i) begin
      checkOutput("rst_ready", bus.ready_and_o, 0);
      checkOutput("rst_v_o", bus.v_o, 0);
      checkOutput("rst_err", bus.err_o, 0);
      checkOutput("rst_rdata", bus.rdata_o, 0);
      checkOutput("rst_strobes", {client_w_v_o, client_r_v_o}, 0);
      checkOutput("rst_irq", irq_o, 0);
    end else begin
      expReady = readyArmed && (expQ.size() < OUTS);
      checkOutput("ready", bus.ready_and_o, expReady);
      accept = bus.v_i && expReady;
      err    = reqError(bus.addr_i, bus.size_i);
      idx    = int'((bus.addr_i - BASE) >> CAW);
      expW   = '0;
      expR   = '0;
      if (accept && !err) begin
        if (bus.wr_en_i) expW[idx] = 1'b1;
        else             expR[idx] = 1'b1;
      end
      checkOutput("w_strobe", client_w_v_o, expW);
      checkOutput("r_strobe", client_r_v_o, expR);
      if ((expW | expR) != '0) begin
        checkOutput("client_addr", client_addr_o, (bus.addr_i - BASE) % (32'd1 << CAW));
        checkOutput("client_size", client_size_o, bus.size_i);
        checkOutput("client_wdata", client_wdata_o, bus.wdata_i);
      end
      expV = (expQ.size() > 0) && (cycleNum >= expQ[0].cyc + 2);
      checkOutput("v_o", bus.v_o, expV);
      if (expV) begin
        checkOutput("rdata", bus.rdata_o, expQ[0].data);
        checkOutput("err", bus.err_o, expQ[0].err);
        if (bus.ready_and_i) begin
          lastRespData = bus.rdata_o;
          lastRespErr  = bus.err_o;
          void'(expQ.pop_front());
        end
      end
      checkOutput("irq_o", irq_o, irqPrev);
      if (accept) begin
        lastAccepted = 1;
        acceptCount++;
        r.cyc  = cycleNum;
        r.err  = err;
        r.data = '0;
        if (!err && !bus.wr_en_i) begin
          schedPending = 1;
          schedIdx     = idx;
          schedValid   = !(forceWithhold || ($urandom_range(99) < withholdPct));
          schedData    = forceDataEn ? forceData : $urandom;
          if (schedValid) r.data = readValue(schedData, bus.addr_i, bus.size_i);
          else            r.err  = 1'b1;
        end
        expQ.push_back(r);
      end
    end
    @(posedge clk_i);
    #1;
    readyArmed = reset_n_i;
    irqPrev    = reset_n_i && (|irq_i);
    for (int c = 0; c < NC; c++) client_rdata_i[c*DW +: DW] = $urandom;
    client_rdata_v_i = NC'($urandom);
    if (schedPending) begin
      client_rdata_v_i[schedIdx] = schedValid;
      if (schedValid) client_rdata_i[schedIdx*DW +: DW] = schedData;
      schedPending = 0;
    end
  endtask

  task automatic applyStimulus(bit wr, logic [31:0] addr, logic [1:0] size, logic [31:0] wdata,
                               int maxWait, output bit accepted);
    bus.v_i     = 1'b1;
    bus.wr_en_i = wr;
    bus.addr_i  = addr;
    bus.size_i  = size;
    bus.wdata_i = wdata;
    accepted    = 0;
    for (int w = 0; w < maxWait && !accepted; w++) begin
      runCycle();
      accepted = lastAccepted;
    end
    bus.v_i = 1'b0;
  endtask

  task automatic idle(int n);
    bus.v_i = 1'b0;
    repeat (n) runCycle();
  endtask

  task automatic doReset(int n);
    reset_n_i    = 1'b0;
    bus.v_i      = 1'b0;
    expQ.delete();
    readyArmed   = 0;
    irqPrev      = 0;
    schedPending = 0;
    repeat (n) runCycle();
    reset_n_i = 1'b1;
  endtask

  initial begin
    bit acc;
    int okCount;
    bus.v_i = 0; bus.wr_en_i = 0; bus.addr_i = 0; bus.size_i = 0; bus.wdata_i = 0;
    bus.ready_and_i = 1; irq_i = 0; client_rdata_i = 0; client_rdata_v_i = 0;
    doReset(3);
    idle(2);

    applyStimulus(1, 32'h0001_0004, 2, 32'hA5A5_1234, 5, acc);
    idle(3);
    checkOutput("wr_resp_err", lastRespErr, 0);

    forceDataEn = 1; forceData = 32'hCAFE_F00D;
    applyStimulus(0, 32'h0001_0004, 2, 0, 5, acc);
    forceDataEn = 0;
    idle(3);
    checkOutput("rd_cafe", lastRespData, 32'hCAFE_F00D);

    forceDataEn = 1; forceData = 32'h1122_3344;
    applyStimulus(0, 32'h0000_0002, 0, 0, 5, acc);
    forceDataEn = 0;
    idle(3);
    checkOutput("byte_rd_data", lastRespData, 32'h22);
    checkOutput("byte_rd_err", lastRespErr, 0);

    applyStimulus(0, 32'h0002_0000, 2, 0, 5, acc);
    idle(3);
    checkOutput("unmapped_err", {lastRespErr, lastRespData}, {1'b1, 32'h0});
    applyStimulus(0, 32'h0000_0001, 1, 0, 5, acc);
    idle(3);
    checkOutput("misaligned_err", {lastRespErr, lastRespData}, {1'b1, 32'h0});
    applyStimulus(0, 32'h0000_0000, 3, 0, 5, acc);
    idle(3);
    checkOutput("oversize_err", {lastRespErr, lastRespData}, {1'b1, 32'h0});

    forceWithhold = 1;
    applyStimulus(0, 32'h0000_0008, 2, 0, 5, acc);
    forceWithhold = 0;
    idle(3);
    checkOutput("timeout_err", lastRespErr, 1);

    irq_i = 2'b01;
    runCycle();
    checkOutput("irq_spec", irq_o, 1);
    irq_i = 2'b00;
    idle(2);

    // Credit limit: four accepted with the consumer stalled, the fifth waits for a drain.
    bus.ready_and_i = 0;
    okCount = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 32'h0000_0000 + 32'(4 * i), 2, 0, (i < 4) ? 1 : 3, acc);
      okCount += int'(acc);
    end
    checkOutput("credit_accepts", okCount, 4);
    checkOutput("credit_full", bus.ready_and_o, 0);
    bus.ready_and_i = 1;
    applyStimulus(0, 32'h0001_0010, 2, 0, 10, acc);
    checkOutput("credit_fifth", acc, 1);
    idle(8);

    bus.ready_and_i = 0;
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0001_0000, 2, 0, 2, acc);
    doReset(2);
    bus.ready_and_i = 1;
    runCycle();
    checkOutput("post_rst_ready", bus.ready_and_o, 1);
    idle(4);
    checkOutput("stale_v", bus.v_o, 0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [1:0]  s;
      case ($urandom_range(3))
        0:       a = {16'h0000, 16'($urandom)};
        1:       a = {16'h0001, 16'($urandom)};
        2:       a = {16'($urandom_range(16'hFFFF, 2)), 16'($urandom)};
        default: a = $urandom;
      endcase
      s = 2'($urandom_range(3));
      if ($urandom_range(1) == 1) a = a & ~((32'd1 << s) - 32'd1);
      bus.v_i         = ($urandom_range(9) < 6);
      bus.wr_en_i     = 1'($urandom);
      bus.addr_i      = a;
      bus.size_i      = s;
      bus.wdata_i     = $urandom;
      bus.ready_and_i = ($urandom_range(3) != 0);
      irq_i           = NC'($urandom);
      runCycle();
    end

    bus.v_i = 0;
    bus.ready_and_i = 1;
    for (int n = 0; n < 40 && expQ.size() > 0; n++) runCycle();
    checkOutput("drain", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
